// File: rtl/axi_lite_regbank_pkg.sv
// Shared AXI4-Lite response codes and elaboration helpers for the register bank.
package axi_lite_regbank_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_regbank_dec.sv
// Address decoder: word index, range check and read-only lookup for one AXI channel.
module axi_lite_regbank_dec
  import axi_lite_regbank_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 8,
  parameter logic [63:0] RO_MASK    = 64'h80,
  localparam int         ADDR_LSB   = clog2(DATA_WIDTH / 8),
  localparam int         IW         = clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [IW-1:0]         o_idx,
  output logic                  o_in_range,
  output logic                  o_is_ro
);

  logic       w_upper_clear;
  logic [5:0] w_mask_idx;
  logic       w_unused;

  assign o_idx = i_addr[ADDR_LSB +: IW];

  generate
    if (ADDR_WIDTH > ADDR_LSB + IW) begin : g_upper
      assign w_upper_clear = (i_addr[ADDR_WIDTH-1:ADDR_LSB+IW] == '0);
    end else begin : g_no_upper
      assign w_upper_clear = 1'b1;
    end
  endgenerate

  // Any set bit above the index field is a decode error, not an alias.
  assign o_in_range = w_upper_clear && ({1'b0, o_idx} < (IW + 1)'(NUM_REGS));
  assign w_mask_idx = 6'(o_idx);
  assign o_is_ro    = o_in_range && RO_MASK[w_mask_idx];

  // Sub-word address bits carry no meaning for a word-wide register.
  assign w_unused = ^i_addr[ADDR_LSB-1:0];

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: byte-strobed writable control regs, read-only status regs, write pulses.
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 8,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [63:0] RO_MASK    = 64'h80
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IW = clog2(NUM_REGS);
  localparam int NB = DATA_WIDTH / 8;

  logic                  r_rst_done;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [NB-1:0]         r_w_strb;
  logic                  r_bvalid;
  resp_t                 r_bresp;
  logic [NUM_REGS-1:0]   r_wr_pulse;
  logic                  r_rvalid;
  resp_t                 r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_regs   [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_rd_src [NUM_REGS];

  logic [IW-1:0] w_aw_idx;
  logic [IW-1:0] w_ar_idx;
  logic          w_aw_in_range;
  logic          w_aw_is_ro;
  logic          w_ar_in_range;
  logic          w_ar_is_ro;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_commit;
  logic          w_commit_ok;
  resp_t         w_wr_resp;
  resp_t         w_rd_resp;
  logic          w_unused;

  // The write decoder looks at the held address, so the commit sees a stable index.
  axi_lite_regbank_dec #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .RO_MASK   (RO_MASK)
  ) u_dec_aw (
    .i_addr    (r_aw_addr),
    .o_idx     (w_aw_idx),
    .o_in_range(w_aw_in_range),
    .o_is_ro   (w_aw_is_ro)
  );

  axi_lite_regbank_dec #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .RO_MASK   (RO_MASK)
  ) u_dec_ar (
    .i_addr    (S_AXI_ARADDR),
    .o_idx     (w_ar_idx),
    .o_in_range(w_ar_in_range),
    .o_is_ro   (w_ar_is_ro)
  );

  assign S_AXI_AWREADY = r_rst_done & ~r_aw_held & ~r_bvalid;
  assign S_AXI_WREADY  = r_rst_done & ~r_w_held & ~r_bvalid;
  assign S_AXI_ARREADY = r_rst_done & ~r_rvalid;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign wr_pulse      = r_wr_pulse;

  assign w_aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs      = S_AXI_WVALID & S_AXI_WREADY;
  assign w_ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
  assign w_commit    = r_aw_held & r_w_held;
  assign w_wr_resp   = !w_aw_in_range ? RESP_DECERR : (w_aw_is_ro ? RESP_SLVERR : RESP_OKAY);
  assign w_commit_ok = w_commit && (w_wr_resp == RESP_OKAY);
  assign w_rd_resp   = w_ar_in_range ? RESP_OKAY : RESP_DECERR;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rst_done <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_rst_done <= 1'b1;
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= S_AXI_AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
      end
      // Holding flags and BVALID are mutually exclusive, so commit and B handshake never collide.
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
        if (w_commit_ok) begin
          r_wr_pulse[w_aw_idx] <= 1'b1;
        end
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Reads sample the array before this edge's commit, so a colliding read sees the old value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_resp;
      r_rdata  <= w_ar_in_range ? w_rd_src[w_ar_idx] : '0;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
          r_regs[gi] <= '0;
        end else if (w_commit_ok && (w_aw_idx == IW'(gi))) begin
          for (int b = 0; b < NB; b++) begin
            if (r_w_strb[b]) begin
              r_regs[gi][b*8 +: 8] <= r_w_data[b*8 +: 8];
            end
          end
        end
      end

      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
      assign w_rd_src[gi] = RO_MASK[gi] ? status_in[gi*DATA_WIDTH +: DATA_WIDTH] : r_regs[gi];
    end
  endgenerate

  // Protection bits carry nothing for this slave; status slices of writable regs are don't-care.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, status_in, w_ar_is_ro};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Randomized self-checking bench for axi_lite_regbank against a word-array reference model.
module tb_axi_lite_regbank;

  logic         S_AXI_ACLK;
  logic         S_AXI_ARESETN;
  logic [7:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [7:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [255:0] reg_out;
  logic [255:0] status_in;
  logic [7:0]   wr_pulse;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_regs[8];

  axi_lite_regbank #(
    .DATA_WIDTH(32),
    .NUM_REGS  (8),
    .ADDR_WIDTH(8),
    .RO_MASK   (64'h80)
  ) dut (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWPROT (S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .reg_out      (reg_out),
    .status_in    (status_in),
    .wr_pulse     (wr_pulse)
  );

  initial S_AXI_ACLK = 1'b0;
  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = (i == 7) ? 32'h0 : m_regs[i];
    return f;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
  endtask

  task automatic do_reset(input int ncyc);
    #2;
    S_AXI_ARESETN = 1'b0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_RREADY  = 1'b0;
    #1;
    chk("rst_async_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    chk("rst_async_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    clear_model();
    repeat (ncyc) @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    @(negedge S_AXI_ACLK);
  endtask

  // w_lead > 0: W valid that many cycles before AW; < 0: AW leads. bready_dly < 0 leaves B pending.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, input int bready_dly);
    int          idx, aw_start, w_start, cyc;
    bit          aw_done, w_done, stray;
    logic [1:0]  eresp;
    logic [7:0]  epulse;
    idx = int'(addr[4:2]);
    if (addr[7:5] != 3'b000) begin
      eresp = 2'b11; epulse = 8'h00;
    end else if (idx == 7) begin
      eresp = 2'b10; epulse = 8'h00;
    end else begin
      eresp = 2'b00; epulse = 8'(1 << idx);
      for (int b = 0; b < 4; b++) if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    S_AXI_AWADDR = addr;
    S_AXI_AWPROT = 3'($urandom);
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    aw_done = 0; w_done = 0; stray = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 64) begin
      @(negedge S_AXI_ACLK);
      if (wr_pulse != 8'h00) stray = 1;
      S_AXI_AWVALID = !aw_done && (cyc >= aw_start);
      S_AXI_WVALID  = !w_done && (cyc >= w_start);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      cyc++;
    end
    chk("wr_handshake", {aw_done, w_done}, 2'b11);
    cyc = 0;
    do begin
      @(negedge S_AXI_ACLK);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      if (!S_AXI_BVALID && wr_pulse != 8'h00) stray = 1;
      cyc++;
    end while (!S_AXI_BVALID && cyc < 16);
    chk("b_latency", cyc, 2);
    chk("b_valid", S_AXI_BVALID, 1'b1);
    chk("b_resp", S_AXI_BRESP, eresp);
    chk("wr_pulse", wr_pulse, epulse);
    chk("wr_pulse_early", stray, 1'b0);
    chk("aw_w_ready_blocked", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    chk("reg_out", reg_out, model_flat());
    $display("WR addr=%h data=%h strb=%h lead=%0d resp=%0d pulse=%h", addr, data, strb, w_lead,
             S_AXI_BRESP, wr_pulse);
    if (bready_dly < 0) return;
    for (int k = 0; k < bready_dly; k++) begin
      @(negedge S_AXI_ACLK);
      chk("b_hold", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, eresp});
      chk("b_hold_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
      chk("b_hold_pulse", wr_pulse, 8'h00);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_BREADY = 1'b0;
    chk("b_clear", {S_AXI_BVALID, wr_pulse}, 9'h000);
    chk("aw_w_ready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
  endtask

  task automatic do_read(input logic [7:0] addr, input int rready_dly);
    int          idx, cyc;
    bit          done;
    logic [31:0] edata;
    logic [1:0]  eresp;
    idx = int'(addr[4:2]);
    if (addr[7:5] != 3'b000) begin
      edata = 32'h0; eresp = 2'b11;
    end else if (idx == 7) begin
      edata = status_in[idx*32 +: 32]; eresp = 2'b00;
    end else begin
      edata = m_regs[idx]; eresp = 2'b00;
    end
    S_AXI_ARADDR = addr;
    S_AXI_ARPROT = 3'($urandom);
    done = 0; cyc = 0;
    while (!done && cyc < 32) begin
      @(negedge S_AXI_ACLK);
      S_AXI_ARVALID = 1'b1;
      if (S_AXI_ARREADY) done = 1;
      cyc++;
    end
    chk("ar_handshake", done, 1'b1);
    @(negedge S_AXI_ACLK);
    S_AXI_ARVALID = 1'b0;
    chk("r_valid", S_AXI_RVALID, 1'b1);
    chk("r_data", S_AXI_RDATA, edata);
    chk("r_resp", S_AXI_RRESP, eresp);
    $display("RD addr=%h data=%h resp=%0d", addr, S_AXI_RDATA, S_AXI_RRESP);
    for (int k = 0; k < rready_dly; k++) begin
      @(negedge S_AXI_ACLK);
      chk("r_hold", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, eresp, edata});
      chk("r_hold_arready", S_AXI_ARREADY, 1'b0);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_RREADY = 1'b0;
    chk("r_clear", S_AXI_RVALID, 1'b0);
    chk("ar_ready_back", S_AXI_ARREADY, 1'b1);
  endtask

  initial begin
    logic [7:0] addr;
    bit         seen;
    S_AXI_ARESETN = 1'b0;
    S_AXI_AWADDR  = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    for (int i = 0; i < 8; i++) status_in[i*32 +: 32] = $urandom;
    clear_model();

    // Reset held for 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(negedge S_AXI_ACLK);
      chk("rst_hold", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID},
          5'b00000);
    end
    chk("rst_outputs", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_pulse}, '0);
    chk("rst_reg_out", reg_out, '0);
    S_AXI_ARESETN = 1'b1;
    @(negedge S_AXI_ACLK);
    chk("rst_done_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    for (int i = 0; i < 7; i++) do_read(8'(i * 4), 0);

    for (int i = 0; i < 4; i++) do_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) do_read(8'(i * 4), 1);

    do_write(8'h04, 32'h11223344, 4'hF, 0, 0);
    do_write(8'h04, 32'hAABBCCDD, 4'b0010, 0, 0);
    do_read(8'h04, 0);
    chk("strobe_merge", m_regs[1], 32'h1122CC44);

    do_write(8'h08, 32'h5A5A0001, 4'hF, 3, 0);
    do_write(8'h0C, 32'h5A5A0002, 4'hF, -3, 0);
    do_write(8'h10, 32'h12345678, 4'h0, 0, 0);
    do_read(8'h08, 0);
    do_read(8'h0C, 0);
    do_read(8'h10, 0);

    status_in[7*32 +: 32] = 32'hDEADBEEF;
    do_write(8'h1C, 32'h0BADF00D, 4'hF, 0, 0);
    do_read(8'h1C, 2);
    do_read(8'h20, 0);
    do_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0);

    do_write(8'h14, 32'hC0FFEE00, 4'hF, 0, 5);

    for (int t = 0; t < 60; t++) begin
      addr = 8'($urandom);
      if ($urandom_range(0, 5) != 0) addr[7:5] = 3'b000;
      if ($urandom_range(0, 7) == 0) status_in[($urandom_range(0, 7))*32 +: 32] = $urandom;
      if ($urandom_range(0, 1) == 0)
        do_write(addr, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                 int'($urandom_range(0, 3)));
      else
        do_read(addr, int'($urandom_range(0, 3)));
    end

    // Reset while a write response is pending
    do_write(8'h08, 32'hCAFEF00D, 4'hF, 0, -1);
    do_reset(3);
    chk("rst_mid_reg_out", reg_out, '0);
    do_read(8'h08, 0);

    // Held AW is dropped by reset; a later lone W must not commit
    @(negedge S_AXI_ACLK);
    S_AXI_AWADDR  = 8'h04;
    S_AXI_AWVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 1'b0;
    do_reset(2);
    S_AXI_WDATA  = 32'hFEEDFACE;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_WVALID = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge S_AXI_ACLK);
      if (S_AXI_BVALID || wr_pulse != 8'h00) seen = 1;
    end
    chk("dropped_aw_no_commit", seen, 1'b0);
    chk("dropped_aw_reg_out", reg_out, '0);
    do_reset(2);
    do_read(8'h04, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
